spi_ram_burst: RTL

Parametrised second-generation SPI slave RAM that sits behind the SPI slave interface and consumes its rx_valid/din command words. It has independent write and read address pointers, optional auto-increment for burst access, and a tx_valid/tx_ready handshake back to the SPI slave. It flags out-of-range addresses and dropped reads.

---
 rtl/spi_ram_burst.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/spi_ram_burst.sv
// SPI slave RAM: WR_ADDR/WR_DATA/RD_ADDR/RD_DATA commands with separate write and read pointers and optional burst auto-increment.
// Latency: a write lands at the command edge; read data and tx_valid appear one edge after an accepted RD_DATA.
// Backpressure: dout/tx_valid held until tx_ready; a RD_DATA arriving while the word is still held is dropped and flagged.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   rx_valid, din        command strobe and {opcode[1:0], payload[MEM_WIDTH-1:0]}
//   inc_en               post-increment the pointer used by WR_DATA / RD_DATA
//   tx_ready             downstream accepts dout this cycle
//   dout, tx_valid       read word and its valid flag
//   addr_err, rd_overrun one-cycle error pulses
//   wr_addr_q, rd_addr_q pointer observability
module spi_ram_burst #(
    parameter int MEM_WIDTH = 8,
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 inc_en,
    input  logic                 tx_ready,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 addr_err,
    output logic                 rd_overrun,
    output logic [ADDR_SIZE-1:0] wr_addr_q,
    output logic [ADDR_SIZE-1:0] rd_addr_q
);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [MEM_WIDTH-1:0] mem [0:MEM_DEPTH-1];

    logic [1:0]           cmd_op;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic [MEM_WIDTH-1:0] cmd_dat;
    logic                 cmd_addr_ok;
    logic                 is_wr_addr;
    logic                 is_wr_data;
    logic                 is_rd_addr;
    logic                 is_rd_data;
    logic                 rd_accept;
    logic                 rd_drop;

    assign cmd_op   = din[MEM_WIDTH+1:MEM_WIDTH];
    assign cmd_addr = din[ADDR_SIZE-1:0];
    assign cmd_dat  = din[MEM_WIDTH-1:0];

    // Non-power-of-two depths leave a hole at the top of the address space.
    assign cmd_addr_ok = (32'(cmd_addr) < MEM_DEPTH);

    assign is_wr_addr = rx_valid && (cmd_op == OP_WR_ADDR);
    assign is_wr_data = rx_valid && (cmd_op == OP_WR_DATA);
    assign is_rd_addr = rx_valid && (cmd_op == OP_RD_ADDR);
    assign is_rd_data = rx_valid && (cmd_op == OP_RD_DATA);

    // A read is taken whenever the output slot is free or is being emptied this cycle.
    assign rd_accept = is_rd_data && ((state_q == S_IDLE) || tx_ready);
    assign rd_drop   = is_rd_data && (state_q == S_HOLD) && !tx_ready;

    // Pointer post-increment, wrapping at the configured depth rather than 2**ADDR_SIZE.
    function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
        if (32'(p) == MEM_DEPTH - 1) begin
            return '0;
        end
        return p + ADDR_SIZE'(1);
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rd_accept) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rd_accept) begin
                    state_d = S_HOLD;
                end else if (tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        tx_valid = (state_q == S_HOLD);
    end

    // Storage has no reset so it can map onto a plain RAM; contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && is_wr_data) begin
            mem[wr_addr_q] <= cmd_dat;
        end
    end

    // Datapath registers: pointers, read word and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            addr_err   <= 1'b0;
            rd_overrun <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            addr_err   <= (is_wr_addr || is_rd_addr) && !cmd_addr_ok;
            rd_overrun <= rd_drop;

            if (is_wr_addr && cmd_addr_ok) begin
                wr_addr_q <= cmd_addr;
            end else if (is_wr_data && inc_en) begin
                wr_addr_q <= next_ptr(wr_addr_q);
            end

            if (is_rd_addr && cmd_addr_ok) begin
                rd_addr_q <= cmd_addr;
            end else if (rd_accept && inc_en) begin
                rd_addr_q <= next_ptr(rd_addr_q);
            end

            // Commands are serialised, so a write on the previous edge is already visible here.
            if (rd_accept) begin
                dout <= mem[rd_addr_q];
            end
        end
    end

endmodule
